// File: rtl/slon_adc_pkg.sv
// Shared types and default parameters for the ADC receive path.
package slon_adc_pkg;

    localparam int DIN_WIDTH_DEF    = 12;
    localparam int CLK_FACTOR_DEF   = 8;
    localparam int SAMPLE_PHASE_DEF = 6;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int SAMPLE_CNT_W     = 32;

    typedef bit [DIN_WIDTH_DEF-1:0]           Sample_t;
    typedef bit [$clog2(CLK_FACTOR_DEF)-1:0]  Phase_t;

endpackage

// File: rtl/slon_sfifo.sv
// Single-clock sample FIFO with a registered output stage; occupancy counts every
// stored word, including the one currently presented on o_dout.
module slon_sfifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    logic             w_rd_en;
    logic             w_wr_en;
    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_cnt_left;

    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign w_rd_en    = i_pop && r_valid;
    assign w_wr_en    = i_push && (!o_full || w_rd_en);
    assign w_rd_nxt   = r_rd + AW'(w_rd_en);
    assign w_cnt_left = r_cnt - CW'(w_rd_en);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // The output stage looks only at words stored before this edge, which gives
    // the one-cycle push-to-valid delay and keeps o_valid independent of i_pop timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr <= r_wr + AW'(1);
            end
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_left + CW'(w_wr_en);
            r_valid <= (w_cnt_left != '0);
            r_dout  <= r_mem[w_rd_nxt];
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;

endmodule

// File: rtl/slon_adc_rx.sv
// ADC receiver: divided converter clock, fixed-phase capture of the registered pin
// word, sample FIFO onto a valid/ready stream, sticky overflow and sample counter.
module slon_adc_rx
    import slon_adc_pkg::*;
#(
    parameter int DIN_WIDTH    = DIN_WIDTH_DEF,
    parameter int CLK_FACTOR   = CLK_FACTOR_DEF,
    parameter int SAMPLE_PHASE = SAMPLE_PHASE_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    adc_clk,
    input  logic [DIN_WIDTH-1:0]    adc_din,
    output logic [DIN_WIDTH-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

    localparam int              PH_W      = $clog2(CLK_FACTOR);
    localparam logic [PH_W-1:0] PH_RISE   = PH_W'(CLK_FACTOR / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_FACTOR - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);

    logic [PH_W-1:0]         r_phase;
    logic                    r_adc_clk;
    logic [DIN_WIDTH-1:0]    r_din_q;
    logic                    r_ovf;
    logic [SAMPLE_CNT_W-1:0] r_sample_cnt;

    logic                    w_strobe;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_valid;
    logic [DIN_WIDTH-1:0]    w_data;

    assign w_strobe = en && (r_phase == PH_SAMPLE);
    assign w_pop    = w_valid && m_ready && !w_empty;
    assign w_push   = w_strobe && (!w_full || w_pop);
    assign w_drop   = w_strobe && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= '0;
            r_adc_clk <= 1'b0;
        end else if (!en) begin
            r_phase   <= '0;
            r_adc_clk <= 1'b0;
        end else begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
            if (r_phase == PH_RISE) begin
                r_adc_clk <= 1'b1;
            end else if (r_phase == PH_LAST) begin
                r_adc_clk <= 1'b0;
            end
        end
    end

    // Pins are only ever seen through this flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_q <= '0;
        end else begin
            r_din_q <= adc_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf        <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_push) begin
                r_sample_cnt <= r_sample_cnt + SAMPLE_CNT_W'(1);
            end
        end
    end

    slon_sfifo #(
        .WIDTH (DIN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (r_din_q),
        .i_pop   (w_pop),
        .o_dout  (w_data),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign adc_clk    = r_adc_clk;
    assign m_data     = w_data;
    assign m_valid    = w_valid;
    assign ovf        = r_ovf;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_slon_adc_rx.sv
// Scoreboard bench for slon_adc_rx: directed periods push expected samples, a
// negedge monitor pops and compares every delivered word.
module tb_slon_adc_rx;
    import slon_adc_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic        adc_clk;
    logic [11:0] adc_din;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        ovf;
    logic        ovf_clr;
    logic [31:0] sample_cnt;

    int          checks   = 0;
    int          failures = 0;
    Sample_t     exp_q[$];
    logic [31:0] exp_cnt  = 0;

    slon_adc_rx dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adc_clk    (adc_clk),
        .adc_din    (adc_din),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One adc_clk period starting at counter 0; m_ready changes after the first edge
    // so the previous period's sample (transferred on that edge) is not disturbed.
    task automatic period(input Sample_t v, input bit acc, input bit rdy, input bit chk_wave);
        int pulses = 0;
        adc_din = v;
        if (acc) begin
            exp_q.push_back(v);
            exp_cnt++;
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 1) m_ready = rdy;
            if (chk_wave) begin
                chk("adc_clk_wave", 32'(adc_clk), 32'((k >= 4) && (k <= 7)));
                pulses += int'(m_valid);
            end
        end
        if (chk_wave) chk("valid_pulses", 32'(pulses), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        adc_din = '0;
        #3;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sample_cnt", sample_cnt, 32'd0);
        chk("rst_adc_clk", 32'(adc_clk), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick(1);

        // ramp, free-flowing stream, waveform and one valid pulse per period
        m_ready = 1'b1;
        en      = 1'b1;
        for (int p = 0; p < 4; p++) period(Sample_t'(p), 1'b1, 1'b1, 1'b1);
        chk("ramp_ovf", 32'(ovf), 32'd0);
        chk("ramp_cnt", sample_cnt, exp_cnt);

        // push-to-valid latency
        adc_din = 12'hABC;
        exp_q.push_back(12'hABC);
        exp_cnt++;
        tick(7);
        chk("lat_not_yet", 32'(m_valid), 32'd0);
        tick(1);
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_data", 32'(m_data), 32'hABC);

        // backpressure: four held, two dropped
        for (int p = 0; p < 4; p++) period(Sample_t'(12'h100 + p), 1'b1, 1'b0, 1'b0);
        period(12'h104, 1'b0, 1'b0, 1'b0);
        period(12'h105, 1'b0, 1'b0, 1'b0);
        chk("full_ovf", 32'(ovf), 32'd1);
        chk("full_cnt", sample_cnt, exp_cnt);
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'h100);

        // ovf_clr on the same edge as a drop: set wins
        adc_din = 12'h106;
        tick(6);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("clr_vs_drop", 32'(ovf), 32'd1);
        tick(1);

        // plain clear, then push and pop on the same strobe edge while full
        adc_din = 12'h107;
        exp_q.push_back(12'h107);
        exp_cnt++;
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        tick(5);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("pushpop_ovf", 32'(ovf), 32'd0);
        chk("pushpop_cnt", sample_cnt, exp_cnt);
        chk("pushpop_data", 32'(m_data), 32'h101);
        tick(1);

        // en dropped at counter 5, drain, restart
        adc_din = 12'h200;
        tick(5);
        chk("pre_en_adc_clk", 32'(adc_clk), 32'd1);
        en = 1'b0;
        tick(1);
        chk("en_off_adc_clk", 32'(adc_clk), 32'd0);
        m_ready = 1'b1;
        tick(10);
        chk("drain_valid", 32'(m_valid), 32'd0);
        chk("drain_cnt", sample_cnt, exp_cnt);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        en      = 1'b1;
        adc_din = 12'h2AA;
        exp_q.push_back(12'h2AA);
        exp_cnt++;
        tick(6);
        chk("restart_early", sample_cnt, exp_cnt - 32'd1);
        tick(1);
        chk("restart_strobe", sample_cnt, exp_cnt);
        tick(1);

        // async reset with three buffered samples
        period(12'h301, 1'b1, 1'b0, 1'b0);
        period(12'h302, 1'b1, 1'b0, 1'b0);
        period(12'h303, 1'b1, 1'b0, 1'b0);
        tick(5);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        chk("pre_rst_adc_clk", 32'(adc_clk), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_data", 32'(m_data), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_cnt", sample_cnt, 32'd0);
        chk("arst_adc_clk", 32'(adc_clk), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        adc_din = 12'h3FF;
        tick(1);
        rst = 1'b0;

        // sample_cnt wrap
        force dut.r_sample_cnt = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_sample_cnt;
        chk("wrap_preset", sample_cnt, 32'hFFFF_FFFF);
        exp_q.push_back(12'h3FF);
        tick(6);
        chk("wrap_zero", sample_cnt, 32'd0);
        tick(3);
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
